neuron_primitives: RTL and testbench

- Support-primitive block for one fixed-point MLP neuron.
- Contains three independent units: a weight memory (one write port, one read port), a ReLU activation with saturation, and a sigmoid lookup ROM.
- Sits inside each neuron. The accumulator feeds the activation inputs, and the input stream drives the weight read address.
- The units share clk and rst only. There is no data path between them.

---
 rtl/neuron_primitives.sv | 122 ++++++++++++
 tb/tb_neuron_primitives.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_primitives.sv
// Per-neuron support primitives: weight RAM, saturating ReLU and sigmoid ROM.
// The three units share only clk and rst.
module neuron_primitives #(
    parameter int numWeight      = 784,
    parameter int addressWidth   = $clog2(numWeight),
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 1,
    parameter int intWidthExtend = addressWidth,
    parameter int sigmoidSize    = 5,
    parameter     weightFile     = "",
    parameter     sigFile        = ""
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      wen,
    input  logic [addressWidth-1:0]                   wadd,
    input  logic [dataWidth-1:0]                      win,
    input  logic                                      ren,
    input  logic [addressWidth:0]                     radd,
    output logic [dataWidth-1:0]                      wout,
    input  logic [2*dataWidth+intWidthExtend-1:0]     relu_x,
    output logic [dataWidth-1:0]                      relu_out,
    input  logic [sigmoidSize-1:0]                    sig_x,
    output logic [dataWidth-1:0]                      sig_out
);

    localparam int RW    = 2*dataWidth + intWidthExtend;
    localparam int TOPN  = intWidthExtend + weightIntWidth + 1;
    localparam int SLICE = 2*dataWidth - 1 - weightIntWidth;
    localparam int SIG_N = 2**sigmoidSize;
    localparam int SH    = 2*weightIntWidth - sigmoidSize;

    localparam logic [addressWidth:0] NUM_W = (addressWidth+1)'(numWeight);
    localparam logic [dataWidth-1:0]  POS_SAT = {1'b0, {(dataWidth-1){1'b1}}};

    // Weight memory

    logic [dataWidth-1:0] mem [numWeight];
    logic                 wadd_ok;
    logic                 radd_ok;

    assign wadd_ok = {1'b0, wadd} < NUM_W;
    assign radd_ok = radd < NUM_W;

    always_ff @(posedge clk) begin
        if (!rst && wen && wadd_ok)
            mem[wadd] <= win;
    end

    always_ff @(posedge clk) begin
        if (rst)
            wout <= '0;
        else if (ren)
            wout <= radd_ok ? mem[radd[addressWidth-1:0]] : '0;
    end

    // ReLU with positive saturation

    logic unused_relu_lsbs;
    assign unused_relu_lsbs = ^relu_x[SLICE-dataWidth:0];

    always_ff @(posedge clk) begin
        if (rst)
            relu_out <= '0;
        else if (relu_x[RW-1])
            relu_out <= '0;
        else if (|relu_x[RW-1 -: TOPN])
            relu_out <= POS_SAT;
        else
            relu_out <= relu_x[SLICE -: dataWidth];
    end

    // Sigmoid ROM. Built from a fixed-point Taylor series of e^-v so the
    // table is an elaboration-time constant without real arithmetic.

    function automatic logic [dataWidth-1:0] sig_entry(input int k);
        logic signed [127:0] s_one;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        logic signed [127:0] num;
        logic signed [127:0] den;
        logic signed [127:0] q;
        logic signed [127:0] qmax;
        s_one = 128'sd1 <<< 60;
        qmax  = 128'((2**(dataWidth-1)) - 1);
        num   = 128'((2**(sigmoidSize-1)) - k);
        den   = 128'sd1;
        if (SH > 0)
            num = num <<< SH;
        if (SH < 0)
            den = den <<< (-SH);
        term = s_one;
        sum  = s_one;
        for (int n = 1; n < 60; n++) begin
            term = (term * num) / (den * 128'(n));
            sum  = sum + term;
        end
        sum = s_one + sum;
        q = ((s_one <<< (dataWidth-weightIntWidth+1)) + sum) / (sum <<< 1);
        if (q > qmax)
            q = qmax;
        return q[dataWidth-1:0];
    endfunction

    logic [dataWidth-1:0]   rom [SIG_N];
    logic [sigmoidSize-1:0] sig_addr;

    for (genvar k = 0; k < SIG_N; k++) begin : g_rom
        localparam logic [dataWidth-1:0] V = sig_entry(k);
        assign rom[k] = V;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sig_addr <= '0;
        else
            sig_addr <= {~sig_x[sigmoidSize-1], sig_x[sigmoidSize-2:0]};
    end

    assign sig_out = rom[sig_addr];

endmodule

// File: tb/tb_neuron_primitives.sv
// Self-checking bench for neuron_primitives: vector table for ReLU/sigmoid,
// hand sequences for the weight RAM, collision and reset.
module tb_neuron_primitives;

    logic               clk = 1'b0;
    logic               rst;
    logic               wen;
    logic [9:0]         wadd;
    logic [15:0]        win;
    logic               ren;
    logic [10:0]        radd;
    logic [15:0]        wout;
    logic signed [41:0] relu_x;
    logic [15:0]        relu_out;
    logic [4:0]         sig_x;
    logic [15:0]        sig_out;

    int checks = 0;
    int failures = 0;

    neuron_primitives dut (
        .clk(clk), .rst(rst),
        .wen(wen), .wadd(wadd), .win(win),
        .ren(ren), .radd(radd), .wout(wout),
        .relu_x(relu_x), .relu_out(relu_out),
        .sig_x(sig_x), .sig_out(sig_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          unit;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic signed [41:0] rx;
        logic [4:0]         sx;
        logic [15:0]        relu_exp;
        logic [15:0]        sig_exp;
    } vec_t;

    vec_t vecs[8];

    task automatic expect_out(input int u, input logic [15:0] e,
                              input string n);
        exp_t t;
        t.unit = u;
        t.exp = e;
        t.name = n;
        sb.push_back(t);
    endtask

    // Passes one rising edge, then compares everything queued for it.
    task automatic cycle();
        exp_t t;
        logic [15:0] act;
        @(negedge clk);
        while (sb.size() > 0) begin
            t = sb.pop_front();
            case (t.unit)
                0: act = wout;
                1: act = relu_out;
                default: act = sig_out;
            endcase
            checks++;
            if (act !== t.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", t.name, act, t.exp);
            end
        end
    endtask

    task automatic write_w(input logic [9:0] a, input logic [15:0] d);
        wen = 1'b1;
        wadd = a;
        win = d;
        cycle();
        wen = 1'b0;
    endtask

    logic [15:0] wdata[4];

    initial begin
        vecs[0] = '{42'sd536870912,    5'd0,     16'h4000, 16'd16384};
        vecs[1] = '{42'sd1073741824,   5'd8,     16'h7FFF, 16'd23955};
        vecs[2] = '{-42'sd1,           5'd15,    16'h0000, 16'd28411};
        vecs[3] = '{42'sd0,            5'b10000, 16'h0000, 16'd3906};
        vecs[4] = '{42'sd32768,        5'b11111, 16'h0001, 16'd15361};
        vecs[5] = '{42'sd1073741823,   5'd0,     16'h7FFF, 16'd16384};
        vecs[6] = '{42'sd17179869183,  5'd8,     16'h7FFF, 16'd23955};
        vecs[7] = '{-42'sd2199023255552, 5'd15,  16'h0000, 16'd28411};
        wdata[0] = 16'h0001;
        wdata[1] = 16'h8000;
        wdata[2] = 16'h7FFF;
        wdata[3] = 16'h1234;

        rst = 1'b1;
        wen = 1'b0;
        wadd = '0;
        win = '0;
        ren = 1'b0;
        radd = '0;
        relu_x = '0;
        sig_x = '0;
        expect_out(0, 16'h0000, "reset_wout");
        expect_out(1, 16'h0000, "reset_relu");
        expect_out(2, 16'd3906, "reset_sig");
        cycle();
        rst = 1'b0;

        foreach (vecs[i]) begin
            relu_x = vecs[i].rx;
            sig_x = vecs[i].sx;
            expect_out(1, vecs[i].relu_exp, $sformatf("relu_v%0d", i));
            expect_out(2, vecs[i].sig_exp, $sformatf("sig_v%0d", i));
            cycle();
        end

        for (int i = 0; i < 4; i++)
            write_w(10'(i), wdata[i]);

        ren = 1'b1;
        for (int i = 0; i < 4; i++) begin
            radd = 11'(i);
            expect_out(0, wdata[i], $sformatf("read_%0d", i));
            cycle();
        end

        ren = 1'b0;
        radd = 11'd0;
        expect_out(0, 16'h1234, "hold_ren0");
        cycle();

        ren = 1'b1;
        radd = 11'd784;
        expect_out(0, 16'h0000, "read_oob");
        cycle();
        ren = 1'b0;

        write_w(10'd5, 16'h0AAA);
        wen = 1'b1;
        wadd = 10'd5;
        win = 16'h0BBB;
        ren = 1'b1;
        radd = 11'd5;
        expect_out(0, 16'h0AAA, "collide_old");
        cycle();
        wen = 1'b0;
        expect_out(0, 16'h0BBB, "collide_new");
        cycle();

        radd = 11'd0;
        relu_x = 42'sd536870912;
        sig_x = 5'd8;
        cycle();
        rst = 1'b1;
        expect_out(0, 16'h0000, "midrst_wout");
        expect_out(1, 16'h0000, "midrst_relu");
        expect_out(2, 16'd3906, "midrst_sig");
        cycle();
        rst = 1'b0;
        radd = 11'd3;
        expect_out(0, 16'h1234, "postrst_read3");
        expect_out(1, 16'h4000, "postrst_relu");
        expect_out(2, 16'd23955, "postrst_sig");
        cycle();
        radd = 11'd1;
        expect_out(0, 16'h8000, "postrst_read1");
        cycle();
        ren = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
